// File: rtl/bsg_clk_gen_pearl_pkg.sv
// Shared types for the clock-generator tag sequencer: command struct, FSM states, width helper.
// Combinational definitions only.
package bsg_clk_gen_pearl_pkg;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int tag_els_gp        = 16;
  localparam int lg_els_gp         = safe_clog2(tag_els_gp);
  localparam int tag_lg_width_gp   = 4;
  localparam int max_payload_gp    = 2**tag_lg_width_gp - 1;
  localparam int init_zeros_gp     = 32;
  localparam int gap_zeros_gp      = 4;

  // Field order puts node_id in the LSBs so {cmd, start_bit} is the wire order, LSB first.
  typedef struct packed {
    logic [max_payload_gp-1:0]  payload;
    logic [tag_lg_width_gp-1:0] len;
    logic                       data_not_reset;
    logic [lg_els_gp-1:0]       node_id;
  } bsg_clk_gen_pearl_tag_cmd_s;

  typedef enum logic [1:0] {
    eINIT = 2'd0,
    eIDLE = 2'd1,
    eSEND = 2'd2,
    eGAP  = 2'd3
  } bsg_clk_gen_pearl_tag_state_e;

endpackage

// File: rtl/bsg_clk_gen_pearl_tag_shifter.sv
// Loadable LSB-first PISO with a bit-down-counter; bit_o is the register LSB.
// Load wins over shift; last_o flags the final counted bit.
module bsg_clk_gen_pearl_tag_shifter
  import bsg_clk_gen_pearl_pkg::*;
#(
  parameter int width_p     = 25,
  parameter int cnt_width_p = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic                   shift_i,
  input  logic [width_p-1:0]     data_i,
  input  logic [cnt_width_p-1:0] count_i,
  output logic                   bit_o,
  output logic                   last_o
);

  logic [width_p-1:0]     data_q, data_d;
  logic [cnt_width_p-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = data_i;
      cnt_d  = count_i;
    end else if (shift_i) begin
      data_d = data_q >> 1;
      if (cnt_q != '0) cnt_d = cnt_q - cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bit_o  = data_q[0];
  assign last_o = (cnt_q == cnt_width_p'(1));

endmodule

// File: rtl/bsg_clk_gen_pearl_tag_seq.sv
// bsg_tag master: serializes ready/valid config commands onto tag_data_o/tag_en_o.
// Start bit one cycle after handshake; ready_o only in IDLE, so commands wait out packet+gap.
module bsg_clk_gen_pearl_tag_seq
  import bsg_clk_gen_pearl_pkg::*;
#(
  parameter int tag_els_p      = tag_els_gp,
  parameter int tag_lg_width_p = tag_lg_width_gp,
  parameter int init_zeros_p   = init_zeros_gp,
  parameter int gap_zeros_p    = gap_zeros_gp,
  localparam int lg_els_lp      = safe_clog2(tag_els_p),
  localparam int max_payload_lp = 2**tag_lg_width_p - 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [lg_els_lp-1:0]      node_id_i,
  input  logic                      data_not_reset_i,
  input  logic [tag_lg_width_p-1:0] len_i,
  input  logic [max_payload_lp-1:0] payload_i,
  output logic                      tag_data_o,
  output logic                      tag_en_o,
  output logic                      done_o
);

  localparam int hdr_bits_lp       = 2 + lg_els_lp + tag_lg_width_p;
  localparam int max_pkt_lp        = hdr_bits_lp + max_payload_lp;
  localparam int cnt_max_lp        = (max_pkt_lp > gap_zeros_p) ? max_pkt_lp : gap_zeros_p;
  localparam int cnt_width_lp      = $clog2(cnt_max_lp + 1);
  localparam int frame_width_lp    = $bits(bsg_clk_gen_pearl_tag_cmd_s) + 1;
  localparam int init_cnt_width_lp = safe_clog2(init_zeros_p);

  bsg_clk_gen_pearl_tag_state_e   state_q, state_d;
  logic [init_cnt_width_lp-1:0]   init_cnt_q, init_cnt_d;
  logic                           done_q, done_d;
  logic                           tag_en_q;

  bsg_clk_gen_pearl_tag_cmd_s     cmd_n;
  logic                           sh_load, sh_shift, sh_bit, sh_last;
  logic [frame_width_lp-1:0]      sh_data;
  logic [cnt_width_lp-1:0]        sh_count;

  // Payload bits at or above len are zeroed so the frame never carries stale data.
  always_comb begin
    cmd_n.node_id        = node_id_i;
    cmd_n.data_not_reset = data_not_reset_i;
    cmd_n.len            = len_i;
    cmd_n.payload        = payload_i & ~({max_payload_lp{1'b1}} << len_i);
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    done_d     = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_data    = '0;
    sh_count   = '0;
    unique case (state_q)
      eINIT: begin
        if (init_cnt_q == init_cnt_width_lp'(init_zeros_p - 1)) state_d = eIDLE;
        else init_cnt_d = init_cnt_q + init_cnt_width_lp'(1);
      end
      eIDLE: begin
        if (v_i) begin
          sh_load  = 1'b1;
          sh_data  = {cmd_n, 1'b1};
          sh_count = cnt_width_lp'(hdr_bits_lp) + cnt_width_lp'(len_i);
          state_d  = eSEND;
        end
      end
      eSEND: begin
        // Reloading zeros on the last bit reuses the counter for the gap.
        if (sh_last) begin
          sh_load  = 1'b1;
          sh_count = cnt_width_lp'(gap_zeros_p);
          state_d  = eGAP;
        end else begin
          sh_shift = 1'b1;
        end
      end
      eGAP: begin
        if (sh_last) begin
          state_d = eIDLE;
          done_d  = 1'b1;
        end else begin
          sh_shift = 1'b1;
        end
      end
      default: state_d = eINIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= eINIT;
      init_cnt_q <= '0;
      done_q     <= 1'b0;
      tag_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      done_q     <= done_d;
      tag_en_q   <= 1'b1;
    end
  end

  bsg_clk_gen_pearl_tag_shifter #(
    .width_p     (frame_width_lp),
    .cnt_width_p (cnt_width_lp)
  ) shifter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (sh_data),
    .count_i (sh_count),
    .bit_o   (sh_bit),
    .last_o  (sh_last)
  );

  assign ready_o    = (state_q == eIDLE);
  assign tag_data_o = sh_bit;
  assign tag_en_o   = tag_en_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_bsg_clk_gen_pearl_tag_seq.sv
// Bench for the tag sequencer: queue-based stream model checked every cycle, plus literal packet checks.
module tb_bsg_clk_gen_pearl_tag_seq;

  localparam int INITZ = 32;
  localparam int GAPZ  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v = 1'b0;
  logic        ready;
  logic [3:0]  node = '0;
  logic        dnr = 1'b0;
  logic [3:0]  len = '0;
  logic [14:0] payload = '0;
  logic        data, en, done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bsg_clk_gen_pearl_tag_seq dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .v_i              (v),
    .ready_o          (ready),
    .node_id_i        (node),
    .data_not_reset_i (dnr),
    .len_i            (len),
    .payload_i        (payload),
    .tag_data_o       (data),
    .tag_en_o         (en),
    .done_o           (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a queue of pending wire bits (packet + gap zeros), an init countdown, a busy flag.
  bit   m_q[$];
  int   m_init;
  bit   m_active;
  logic m_data, m_en, m_ready, m_done;

  always @(posedge clk or posedge rst) begin
    bit hs, empty_before;
    if (rst) begin
      m_q.delete();
      m_init = INITZ; m_active = 0;
      m_data = 0; m_en = 0; m_ready = 0; m_done = 0;
    end else begin
      hs = m_ready && v;
      empty_before = (m_q.size() == 0);
      m_done = m_active && empty_before;
      if (m_active && empty_before) m_active = 0;
      if (m_init > 0) m_init--;
      if (hs) begin
        m_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) m_q.push_back(node[i]);
        m_q.push_back(dnr);
        for (int i = 0; i < 4; i++) m_q.push_back(len[i]);
        for (int i = 0; i < int'(len); i++) m_q.push_back(payload[i]);
        for (int i = 0; i < GAPZ; i++) m_q.push_back(1'b0);
        m_active = 1;
      end
      m_data  = (m_q.size() > 0) ? m_q.pop_front() : 1'b0;
      m_ready = (m_init == 0) && !m_active;
      m_en    = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("tag_data", data, m_data);
    check("tag_en", en, m_en);
    check("ready", ready, m_ready);
    check("done", done, m_done);
  end

  task automatic wait_init();
    int rel, off;
    rel = cyc;
    off = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) begin off = cyc - rel; break; end
    end
    check("init_ready_cycle", off, INITZ);
  endtask

  task automatic run_pkt(input logic [3:0] nd, input logic d, input logic [3:0] l,
                         input logic [14:0] pl, input int p,
                         output logic [31:0] bits, output int hs_c, output int done_c);
    int g;
    @(negedge clk);
    node = nd; dnr = d; len = l; payload = pl; v = 1'b1;
    g = 0;
    while (!ready && g < 100) begin @(negedge clk); g++; end
    check("hs_wait_bound", (g < 100), 1);
    hs_c = cyc;
    bits = '0;
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      if (i == 0) begin v = 1'b0; payload = ~pl; end
      bits = {bits[30:0], data};
    end
    done_c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin done_c = cyc; break; end
    end
  endtask

  logic [3:0]  bn[3] = '{4'd5, 4'd10, 4'd1};
  logic        bd[3] = '{1'b1, 1'b0, 1'b1};
  logic [3:0]  bl[3] = '{4'd2, 4'd7, 4'd15};
  logic [14:0] bp[3] = '{15'h0003, 15'h0055, 15'h1234};

  task automatic apply(input int k, input bit garbage);
    node = bn[k]; dnr = bd[k]; len = bl[k];
    payload = garbage ? ~bp[k] : bp[k];
  endtask

  initial begin
    logic [31:0] bits;
    int hs_c, done_c, k, sub, g;
    int hs[3];

    repeat (2) @(negedge clk);
    check("rst_en", en, 1'b0);
    check("rst_data", data, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_done", done, 1'b0);
    #2 rst = 1'b0;
    wait_init();

    // node 3, data, len 5, payload 10101
    run_pkt(4'd3, 1'b1, 4'd5, 15'b10101, 15, bits, hs_c, done_c);
    check("pkt1_stream", bits, 32'(15'b111001101010101));
    check("pkt1_done", done_c - hs_c, 20);

    // node 15, reset packet, full payload
    run_pkt(4'd15, 1'b0, 4'd15, 15'h7FFF, 25, bits, hs_c, done_c);
    check("pkt2_stream", bits, 32'(25'b1111101111111111111111111));
    check("pkt2_done", done_c - hs_c, 30);

    // payload bits above len ignored
    run_pkt(4'd15, 1'b0, 4'd3, 15'h7FF8, 13, bits, hs_c, done_c);
    check("pkt3_stream", bits, 32'(13'b1111101100000));
    check("pkt3_done", done_c - hs_c, 18);

    // zero-length payload
    run_pkt(4'd0, 1'b1, 4'd0, 15'h7FFF, 10, bits, hs_c, done_c);
    check("pkt4_stream", bits, 32'(10'b1000010000));
    check("pkt4_done", done_c - hs_c, 15);

    // back-to-back with valid held high and payload scrambled mid-packet
    @(negedge clk);
    apply(0, 0); v = 1'b1;
    k = 0; sub = 0; g = 0;
    while (k < 3 && g < 300) begin
      if (ready) begin hs[k] = cyc; k++; sub = 0; end
      @(negedge clk); g++;
      if (k < 3) begin
        sub++;
        if (sub == 1) apply(k, 1);
        if (sub == 4) apply(k, 0);
      end
    end
    v = 1'b0;
    check("b2b_count", k, 3);
    if (k == 3) begin
      check("b2b_space01", hs[1] - hs[0], 12 + 5);
      check("b2b_space12", hs[2] - hs[1], 17 + 5);
    end
    done_c = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin done_c = cyc; break; end
    end
    if (k == 3) check("b2b_done", done_c - hs[2], 30);

    // reset in the middle of a packet
    @(negedge clk);
    node = 4'd3; dnr = 1'b1; len = 4'd5; payload = 15'b10101; v = 1'b1;
    g = 0;
    while (!ready && g < 100) begin @(negedge clk); g++; end
    check("rst_pkt_hs_bound", (g < 100), 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) v = 1'b0;
    end
    check("pre_rst_bit7", data, 1'b1);
    check("pre_rst_en", en, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_data", data, 1'b0);
    check("async_rst_en", en, 1'b0);
    check("async_rst_ready", ready, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    wait_init();
    run_pkt(4'd0, 1'b1, 4'd0, 15'h0, 10, bits, hs_c, done_c);
    check("post_rst_stream", bits, 32'(10'b1000010000));
    check("post_rst_done", done_c - hs_c, 15);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
